i2s_transmitter: RTL and testbench
==================================

# i2s_transmitter

Serializes processed 16-bit signed stereo samples from the effects chain, at the output of the distortion stage, onto an I2S link to the audio DAC/codec. Generates BCLK and LRCLK from the system clock and holds one pending stereo sample in a single-entry buffer with a valid/ready handshake. Sends silence and flags an underrun when no sample is pending at a frame boundary.

## Interface
Parameters:
- `CLK_DIV`, default 4: BCLK half-period in `clk` cycles. Legal values are ≥2. BCLK period is 2·CLK_DIV clk cycles.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `reset_n`, input, 1: synchronous active-low reset.
- `leftSampleIn`, input, 16: signed left sample, two's complement.
- `rightSampleIn`, input, 16: signed right sample.
- `sampleValid`, input, 1: upstream stereo pair is valid.
- `sampleReady`, output, 1: buffer empty; the pair is accepted when valid and ready are both high.
- `bclk`, output, 1: I2S bit clock.
- `lrclk`, output, 1: word select. 0 = left, 1 = right.
- `sdata`, output, 1: serial data, MSB first.
- `frameStart`, output, 1: one-clk pulse when a new frame is loaded.
- `underrun`, output, 1: one-clk pulse when a frame is loaded with zeros.

## Operation
- Reset (`reset_n`=0 at a clk edge) clears all state:
  - `divCnt` = 0, `bclk` = 0, `lrclk` = 0, `sdata` = 0.
  - Slot counter `slot` = 0.
  - 32-bit shift register `shReg` = 0, buffer flag `full` = 0.
  - `frameStart` = 0, `underrun` = 0.
  - `sampleReady` = 1, because it is `!full`.
  - Reset has priority over accept; no sample is accepted in a reset cycle.
- Divider:
  - `divCnt` counts 0..CLK_DIV-1 and wraps.
  - When `divCnt` = CLK_DIV-1, `bclk` toggles.
  - A falling event (FE) is a toggle with `bclk`=1 beforehand.
- Slots:
  - `slot` is 5 bits and increments on every FE, wrapping 31→0.
  - `lrclk` is registered: 0 while `slot` is 0..15, 1 while `slot` is 16..31. It updates on the FE that changes `slot`.
- Buffer:
  - On `sampleValid && sampleReady`, `{leftSampleIn, rightSampleIn}` is stored in `hold` and `full` is set to 1.
  - `sampleReady` = `!full`. It is combinational from the registered flag.
- Load (FE entering `slot` = 1):
  - If `full`: `shReg` ← `hold`, `full` ← 0, `frameStart` pulses.
  - Else: `shReg` ← 0, `frameStart` and `underrun` both pulse.
  - Same-cycle case: an accept on the same clk as the load while `full`=0 is stored for the next frame. The current frame still sends zeros and `underrun` fires.
- Shift (every other FE):
  - `shReg` ← `shReg << 1`.
  - `sdata` = `shReg[31]`, taken registered from the updated value.
- Resulting slot contents, which give the standard I2S one-bit delay:
  - Slots 1..16: L[15..0].
  - Slots 17..31: R[15..1].
  - Slot 0 of the next frame: R[0].
- No saturation or width change; bits are sent exactly as received.

## Timing
- First `bclk` rise at clk edge CLK_DIV after reset release. First FE (and first load) at edge 2·CLK_DIV.
- Frame length = 32 BCLK = 64·CLK_DIV clk. With CLK_DIV=4 this is 256 clk, i.e. 48 kHz at 12.288 MHz.
- `sdata`, `lrclk` and `slot` change only on FE, so they are stable at the BCLK rising edge.
- Latency:
  - Accept to load: the next load event after the accept edge.
  - Load to first MSB on `sdata`: 0 clk. The MSB appears on the load edge.
- Backpressure: after an accept, `sampleReady` stays 0 until the clk after the next load. At most one pair is accepted per frame.
- Reset mid-frame: on the next clk all outputs take their reset values and the pending sample is discarded. The frame restarts from slot 0.

## Test plan
- Reset check: hold `reset_n`=0 for 5 clk with `sampleValid`=1. Required: `bclk`, `lrclk`, `sdata`, `frameStart` and `underrun` all 0; `sampleReady`=1; nothing stored. After release, `underrun` pulses at clk 8 (CLK_DIV=4).
- Serialization: accept L=0x8001, R=0x7FFE before the first load. Sampling `sdata` on BCLK rises must give:
  - Slots 1..16: 1,0×14,1.
  - Slots 17..31: 0,1×14.
  - Next slot 0: 0.
  - `lrclk` 0→1 on the FE into slot 16.
  - `frameStart` pulses once; `underrun` stays 0.
- Underrun: no `sampleValid` for two frames. Required: `sdata`=0 throughout; `underrun` and `frameStart` pulse once per frame, 256 clk apart.
- Backpressure: offer 0x1234/0x5678, then immediately 0xAAAA/0x5555 with `sampleValid` held high. Required:
  - `sampleReady` drops after the first accept.
  - The second pair is accepted only on the clk after the next load.
  - Frames carry the pairs in order.
- Same-cycle accept: assert `sampleValid` only on the load clk with `full`=0. Required: that frame is zeros with `underrun`=1; the next frame carries the pair.
- Parameter and reset: use CLK_DIV=2 (BCLK period 4 clk, frame 128 clk) and assert reset at slot 20. Required: the outputs clear and the frame restarts with the first load 4 clk after release.

Source files
------------

// File: rtl/i2s_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_transmitter
//
// Serializes 16-bit signed stereo samples onto an I2S link. BCLK and LRCLK are
// derived from the system clock; one stereo pair can be held pending in a
// single-entry buffer behind a valid/ready handshake. A frame boundary with no
// pending pair sends silence and raises an underrun pulse.
//
// Parameters:
//   CLK_DIV        BCLK half-period in clk cycles (>= 2)
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        synchronous active-low reset
//   leftSampleIn   left sample, two's complement
//   rightSampleIn  right sample, two's complement
//   sampleValid    upstream pair valid
//   sampleReady    buffer empty; pair taken when valid && ready
//   bclk           I2S bit clock
//   lrclk          word select, 0 = left, 1 = right
//   sdata          serial data, MSB first, one-bit I2S delay
//   frameStart     one-clk pulse when a frame is loaded
//   underrun       one-clk pulse when a frame is loaded with zeros
// -----------------------------------------------------------------------------
module i2s_transmitter #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] leftSampleIn,
    input  logic [15:0] rightSampleIn,
    input  logic        sampleValid,
    output logic        sampleReady,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        frameStart,
    output logic        underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic             bclk_r;
    logic             lrclk_r;
    logic             sdata_r;
    logic [4:0]       slot_r;
    logic [31:0]      sh_reg_r;
    logic [31:0]      hold_r;
    logic             full_r;
    logic             frame_start_r;
    logic             underrun_r;

    logic             tick_s;
    logic             fe_s;
    logic [4:0]       slot_next_s;
    logic             load_s;
    logic             accept_s;
    logic [31:0]      sh_next_s;

    // Divider terminal count, BCLK falling events, frame load and next shift value.
    always_comb begin
        tick_s      = (div_cnt_r == DIV_LAST);
        fe_s        = tick_s & bclk_r;
        slot_next_s = slot_r + 5'd1;
        // A frame is loaded on the falling event that enters slot 1, which
        // puts the MSB one BCLK after the LRCLK transition (I2S delay).
        load_s      = fe_s & (slot_next_s == 5'd1);
        accept_s    = sampleValid & ~full_r;
        sh_next_s   = sh_reg_r;
        if (load_s) begin
            if (full_r) begin
                sh_next_s = hold_r;
            end else begin
                sh_next_s = 32'd0;
            end
        end else if (fe_s) begin
            sh_next_s = {sh_reg_r[30:0], 1'b0};
        end else begin
            sh_next_s = sh_reg_r;
        end
    end

    // Clock divider and BCLK generation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= 1'b0;
        end else begin
            if (tick_s) begin
                div_cnt_r <= {DIV_W{1'b0}};
                bclk_r    <= ~bclk_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
                bclk_r    <= bclk_r;
            end
        end
    end

    // Slot counter, word select, shift register and serial data; all move on FE only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_r   <= 5'd0;
            lrclk_r  <= 1'b0;
            sdata_r  <= 1'b0;
            sh_reg_r <= 32'd0;
        end else begin
            sh_reg_r <= sh_next_s;
            if (fe_s) begin
                slot_r  <= slot_next_s;
                lrclk_r <= slot_next_s[4];
                // Registered from the updated shift value, so the MSB is on
                // the line on the very edge the frame is loaded.
                sdata_r <= sh_next_s[31];
            end else begin
                slot_r  <= slot_r;
                lrclk_r <= lrclk_r;
                sdata_r <= sdata_r;
            end
        end
    end

    // Single-entry sample buffer with valid/ready handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_r <= 32'd0;
            full_r <= 1'b0;
        end else begin
            // An accept can only coincide with a load when the buffer was
            // empty; then the pair is kept for the following frame.
            if (load_s && full_r) begin
                full_r <= 1'b0;
            end else if (accept_s) begin
                full_r <= 1'b1;
            end else begin
                full_r <= full_r;
            end
            if (accept_s) begin
                hold_r <= {leftSampleIn, rightSampleIn};
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    // Frame start and underrun status pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else begin
            frame_start_r <= load_s;
            underrun_r    <= load_s & ~full_r;
        end
    end

    assign sampleReady = ~full_r;
    assign bclk        = bclk_r;
    assign lrclk       = lrclk_r;
    assign sdata       = sdata_r;
    assign frameStart  = frame_start_r;
    assign underrun    = underrun_r;

endmodule

// File: tb/tb_i2s_transmitter.sv
// -----------------------------------------------------------------------------
// tb_i2s_transmitter
//
// Directed bench for i2s_transmitter. Instance a uses CLK_DIV=4 (frame 256
// clk), instance b uses CLK_DIV=2 (frame 128 clk) for the mid-frame reset case.
// Outputs are sampled 1 time unit after the rising clk edge.
// -----------------------------------------------------------------------------
module tb_i2s_transmitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset_n, a_valid, a_ready, a_bclk, a_lrclk, a_sdata, a_fs, a_ur;
    logic [15:0] a_left, a_right;
    logic        b_reset_n, b_valid, b_ready, b_bclk, b_lrclk, b_sdata, b_fs, b_ur;
    logic [15:0] b_left, b_right;

    int checks   = 0;
    int failures = 0;

    i2s_transmitter #(.CLK_DIV(4)) dut_a (
        .clk(clk), .reset_n(a_reset_n),
        .leftSampleIn(a_left), .rightSampleIn(a_right),
        .sampleValid(a_valid), .sampleReady(a_ready),
        .bclk(a_bclk), .lrclk(a_lrclk), .sdata(a_sdata),
        .frameStart(a_fs), .underrun(a_ur)
    );

    i2s_transmitter #(.CLK_DIV(2)) dut_b (
        .clk(clk), .reset_n(b_reset_n),
        .leftSampleIn(b_left), .rightSampleIn(b_right),
        .sampleValid(b_valid), .sampleReady(b_ready),
        .bclk(b_bclk), .lrclk(b_lrclk), .sdata(b_sdata),
        .frameStart(b_fs), .underrun(b_ur)
    );

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer_a(input logic [31:0] pair);
        a_left  = pair[31:16];
        a_right = pair[15:0];
        a_valid = 1'b1;
    endtask

    // Runs one 256-clk frame of instance a starting with its load edge.
    // Stimulus indices refer to the edge after which inputs change.
    task automatic run_frame(input string name, input logic [31:0] exp_bits,
                             input logic exp_ur, input logic rdy0_exp,
                             input int rdy_at, input logic rdy_exp,
                             input int set_at, input logic [31:0] set_pair,
                             input int set2_at, input logic [31:0] set2_pair,
                             input int clr_at);
        int fs_cnt;
        int ur_cnt;
        int k;
        fs_cnt = 0;
        ur_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            adv(1);
            if (a_fs) fs_cnt++;
            if (a_ur) ur_cnt++;
            if (i == 0) begin
                check({name, "_frameStart_at_load"}, 32'(a_fs), 32'd1);
                check({name, "_ready_after_load"}, 32'(a_ready), 32'(rdy0_exp));
            end
            if (i % 8 == 4) begin
                // BCLK rising edge of slot k (k = 32 is slot 0 of the next frame)
                k = i / 8 + 1;
                check($sformatf("%s_sdata_slot%0d", name, k % 32), 32'(a_sdata),
                      32'(exp_bits[32 - k]));
                check($sformatf("%s_lrclk_slot%0d", name, k % 32), 32'(a_lrclk),
                      32'(k >= 16 && k <= 31));
            end
            if (i == rdy_at) check({name, "_ready_mid"}, 32'(a_ready), 32'(rdy_exp));
            if (i == set_at) offer_a(set_pair);
            if (i == set2_at) offer_a(set2_pair);
            if (i == clr_at) a_valid = 1'b0;
        end
        check({name, "_frameStart_count"}, 32'(fs_cnt), 32'd1);
        check({name, "_underrun_count"}, 32'(ur_cnt), 32'(exp_ur));
    endtask

    initial begin
        // ---------------- instance a: reset with valid held high
        a_reset_n = 1'b0; a_valid = 1'b1; a_left = 16'hDEAD; a_right = 16'hBEEF;
        b_reset_n = 1'b0; b_valid = 1'b0; b_left = 16'h0000; b_right = 16'h0000;
        adv(5);
        check("rst_bclk", 32'(a_bclk), 32'd0);
        check("rst_lrclk", 32'(a_lrclk), 32'd0);
        check("rst_sdata", 32'(a_sdata), 32'd0);
        check("rst_frameStart", 32'(a_fs), 32'd0);
        check("rst_underrun", 32'(a_ur), 32'd0);
        check("rst_ready", 32'(a_ready), 32'd1);

        a_reset_n = 1'b1; a_valid = 1'b0;
        adv(3);  check("bclk_before_rise", 32'(a_bclk), 32'd0);
        adv(1);  check("bclk_first_rise", 32'(a_bclk), 32'd1);
        adv(3);  check("underrun_clk7", 32'(a_ur), 32'd0);
                 check("frameStart_clk7", 32'(a_fs), 32'd0);
        adv(1);  check("underrun_clk8", 32'(a_ur), 32'd1);
                 check("frameStart_clk8", 32'(a_fs), 32'd1);
                 check("sdata_clk8", 32'(a_sdata), 32'd0);
        adv(1);  check("underrun_clk9", 32'(a_ur), 32'd0);

        // ---------------- serialization pair accepted at clk 10
        offer_a(32'h8001_7FFE);
        adv(1);  check("ready_after_accept", 32'(a_ready), 32'd0);
        a_valid = 1'b0;
        adv(253);
        run_frame("ser", 32'h8001_7FFE, 1'b0, 1'b1, -1, 1'b0, -1, 32'd0, -1, 32'd0, -1);

        // ---------------- two underrun frames; pair offered only on next load clk
        run_frame("ur1", 32'd0, 1'b1, 1'b1, -1, 1'b0, -1, 32'd0, -1, 32'd0, -1);
        run_frame("ur2", 32'd0, 1'b1, 1'b1, -1, 1'b0, 255, 32'hCAFE_0F0F, -1, 32'd0, -1);

        // ---------------- same-cycle accept: zeros now, pair next frame
        run_frame("same", 32'd0, 1'b1, 1'b0, -1, 1'b0, -1, 32'd0, -1, 32'd0, 0);

        // ---------------- backpressure: second pair waits for the next load
        run_frame("same_next", 32'hCAFE_0F0F, 1'b0, 1'b1, 101, 1'b0,
                  100, 32'h1234_5678, 101, 32'hAAAA_5555, -1);
        run_frame("bp1", 32'h1234_5678, 1'b0, 1'b1, 1, 1'b0, -1, 32'd0, -1, 32'd0, 1);
        run_frame("bp2", 32'hAAAA_5555, 1'b0, 1'b1, -1, 1'b0, -1, 32'd0, -1, 32'd0, -1);

        // ---------------- instance b: CLK_DIV=2, reset during slot 20
        b_reset_n = 1'b1; b_left = 16'h9000; b_right = 16'h0001; b_valid = 1'b1;
        adv(1);  check("b_ready_after_accept", 32'(b_ready), 32'd0);
        b_valid = 1'b0;
        adv(1);  check("b_bclk_first_rise", 32'(b_bclk), 32'd1);
        adv(1);  check("b_frameStart_clk3", 32'(b_fs), 32'd0);
        adv(1);  check("b_frameStart_clk4", 32'(b_fs), 32'd1);
                 check("b_underrun_clk4", 32'(b_ur), 32'd0);
                 check("b_sdata_msb", 32'(b_sdata), 32'd1);
                 check("b_lrclk_slot1", 32'(b_lrclk), 32'd0);
        adv(78); check("b_lrclk_slot20", 32'(b_lrclk), 32'd1);
        b_left = 16'h7777; b_right = 16'h7777; b_valid = 1'b1;
        adv(1);  check("b_ready_pending", 32'(b_ready), 32'd0);
        b_reset_n = 1'b0;
        adv(1);
        check("b_rst_bclk", 32'(b_bclk), 32'd0);
        check("b_rst_lrclk", 32'(b_lrclk), 32'd0);
        check("b_rst_sdata", 32'(b_sdata), 32'd0);
        check("b_rst_frameStart", 32'(b_fs), 32'd0);
        check("b_rst_underrun", 32'(b_ur), 32'd0);
        check("b_rst_ready", 32'(b_ready), 32'd1);
        b_reset_n = 1'b1; b_valid = 1'b0;
        adv(3);  check("b_restart_frameStart_clk3", 32'(b_fs), 32'd0);
        adv(1);  check("b_restart_frameStart_clk4", 32'(b_fs), 32'd1);
                 check("b_restart_underrun_clk4", 32'(b_ur), 32'd1);
                 check("b_restart_sdata", 32'(b_sdata), 32'd0);
                 check("b_restart_lrclk", 32'(b_lrclk), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
